// File: rtl/axi_master.sv
// Single-outstanding AXI-lite style master: one write (AW+W+B) or read (AR+R) per command,
// with per-handshake timeout, sticky error flag and a 7-segment view of the last read data.
module axi_master #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_wr,
    input  logic              start_rd,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rd_data,
    output logic [7:0]        seg_out,
    output logic              m_awvalid,
    output logic [ADDR_W-1:0] m_awaddr,
    input  logic              s_awready,
    output logic              m_wvalid,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              s_wready,
    output logic              m_bready,
    input  logic              s_bvalid,
    input  logic [1:0]        s_bresp,
    output logic              m_arvalid,
    output logic [ADDR_W-1:0] m_araddr,
    input  logic              s_arready,
    output logic              m_rready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    // Last waiting cycle: a handshake-free cycle at this count times out.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              expire;
    logic              aw_hs, w_hs, aw_left, w_left;
    logic [3:0]        nib;
    logic [6:0]        glyph;

    assign expire  = (cnt_q == CNT_LAST);
    assign aw_hs   = awvalid_q & s_awready;
    assign w_hs    = wvalid_q & s_wready;
    assign aw_left = awvalid_q & ~s_awready;
    assign w_left  = wvalid_q & ~s_wready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (start_wr) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    err_d     = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WR_REQ;
                end else if (start_rd) begin
                    addr_d    = cmd_addr;
                    err_d     = 1'b0;
                    arvalid_d = 1'b1;
                    state_d   = RD_REQ;
                end
            end
            WR_REQ: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (!aw_left && !w_left) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end else if (aw_hs || w_hs) begin
                    cnt_d = 8'd0;
                end else if (expire) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_RESP: begin
                if (s_bvalid) begin
                    bready_d = 1'b0;
                    if (s_bresp != 2'b00) err_d = 1'b1;
                    state_d = DONE;
                end else if (expire) begin
                    bready_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RD_REQ: begin
                if (s_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end else if (expire) begin
                    arvalid_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RD_DATA: begin
                if (s_rvalid) begin
                    rready_d  = 1'b0;
                    rd_data_d = s_rdata;
                    if (s_rresp != 2'b00) err_d = 1'b1;
                    state_d = DONE;
                end else if (expire) begin
                    rready_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase

        if (state_d != state_q) cnt_d = 8'd0;

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Glyph segments {g,f,e,d,c,b,a}
    assign nib = 4'(rd_data_q);

    always_comb begin
        glyph = 7'h3F;
        case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
            default: glyph = 7'h3F;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_data   = rd_data_q;
    assign seg_out   = {err_q, glyph};
    assign m_awvalid = awvalid_q;
    assign m_awaddr  = addr_q;
    assign m_wvalid  = wvalid_q;
    assign m_wdata   = wdata_q;
    assign m_bready  = bready_q;
    assign m_arvalid = arvalid_q;
    assign m_araddr  = addr_q;
    assign m_rready  = rready_q;

endmodule

// File: doc/axi_master.md
AXI_MASTER -- requirements
Module: axi_master

Interface
REQ-001 Parameter ADDR_W, default 4, address width in bits.
REQ-002 Parameter DATA_W, default 4, data width in bits.
REQ-003 Parameter TIMEOUT, default 255, maximum wait cycles per handshake, range 1..255.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start_wr  input  1  write-command request, sampled only in IDLE.
REQ-007 start_rd  input  1  read-command request, sampled only in IDLE.
REQ-008 cmd_addr  input  ADDR_W  command address.
REQ-009 cmd_wdata  input  DATA_W  write data.
REQ-010 busy  output  1  transaction in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  sticky error flag: timeout or nonzero response.
REQ-013 rd_data  output  DATA_W  last captured read data.
REQ-014 seg_out  output  8  7-segment image of rd_data, bit order {dp,g,f,e,d,c,b,a}, active high.
REQ-015 m_awvalid / m_awaddr[ADDR_W]  outputs; s_awready  input.
REQ-016 m_wvalid / m_wdata[DATA_W]  outputs; s_wready  input.
REQ-017 m_bready  output; s_bvalid  input; s_bresp[2]  input.
REQ-018 m_arvalid / m_araddr[ADDR_W]  outputs; s_arready  input.
REQ-019 m_rready  output; s_rvalid, s_rdata[DATA_W], s_rresp[2]  inputs.

Function
REQ-020 States SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and DONE.
REQ-021 In IDLE, start_wr=1 SHALL latch cmd_addr and cmd_wdata, clear err, and move to WR_REQ.
REQ-022 In IDLE, start_rd=1 with start_wr=0 SHALL latch cmd_addr, clear err, and move to RD_REQ.
REQ-023 When start_wr and start_rd are both 1, the write SHALL win and the read SHALL be dropped.
REQ-024 Starts outside IDLE SHALL be ignored.
REQ-025 Outputs SHALL be registered; valid goes high the cycle after the start edge.
REQ-026 WR_REQ SHALL assert m_awvalid and m_wvalid together.
REQ-027 In WR_REQ, each valid SHALL drop independently the cycle after its own valid&ready handshake; the two handshakes may complete in either order or in the same cycle.
REQ-028 When both AW and W handshakes are complete, the FSM SHALL move to WR_RESP.
REQ-029 WR_RESP SHALL hold m_bready=1 until s_bvalid=1, then set err if s_bresp!=0 and move to DONE.
REQ-030 RD_REQ SHALL hold m_arvalid=1 until s_arready=1, then move to RD_DATA.
REQ-031 RD_DATA SHALL hold m_rready=1 until s_rvalid=1, then capture s_rdata into rd_data, set err if s_rresp!=0, and move to DONE.
REQ-032 Address and data outputs SHALL stay stable while the matching valid is high.
REQ-033 No valid SHALL drop without a handshake, except on timeout or reset.
REQ-034 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-035 busy SHALL be 1 in every state except IDLE.
REQ-036 An 8-bit wait counter SHALL clear on each state entry and on each handshake, and increment every cycle spent waiting in WR_REQ, WR_RESP, RD_REQ or RD_DATA.
REQ-037 When the wait counter reaches TIMEOUT, all valid/ready outputs SHALL drop on the next cycle, err SHALL be set, and the FSM SHALL enter DONE; rd_data is left unchanged.
REQ-038 seg_out[6:0] SHALL be the hex glyph of rd_data[3:0] (0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71), and seg_out[7] SHALL equal err.

Reset
REQ-039 rst_n=0 SHALL immediately force the FSM to IDLE and drive all valid/ready outputs, busy, done and err to 0, rd_data to 0 and seg_out to 0x3F, including in the middle of a transaction.
REQ-040 After rst_n deasserts, the block SHALL accept a start on the first rising edge.

Verification
REQ-041 Zero-wait slave (all ready/valid tied 1, resp=0), start_wr, addr=3, wdata=A -> awvalid/wvalid high for 1 cycle with awaddr=3, wdata=A; done pulses on cycle 4; err=0.
REQ-042 Read with s_arready delayed 3 cycles, s_rdata=5 -> arvalid held 4 cycles with araddr stable; rd_data=5; seg_out=0x6D; one done pulse.
REQ-043 Write with s_wready at cycle 1 and s_awready at cycle 4 -> wvalid drops after cycle 1, awvalid held through cycle 4, then WR_RESP.
REQ-044 Slave never asserts s_arready, TIMEOUT=8 -> arvalid drops after 8 wait cycles; err=1; seg_out[7]=1; done pulses; next start clears err.
REQ-045 start_wr and start_rd asserted in the same cycle -> only the write is performed; no arvalid.
REQ-046 rst_n pulsed low mid-WR_REQ -> all valids drop without waiting for clk; busy=0; a subsequent read completes normally.
